sequence_generator: RTL and testbench
=====================================

// Module: sequence_generator
// PURPOSE
//   Free-running 3-bit sequence generator: on each clock emits the next code of a fixed 6-step
//   Johnson-style sequence 000->001->011->111->110->100->000.
//   Serves as a pattern source, e.g. for phase/strobe generation, inside synchronous datapaths.
//   Output is fully registered.
// PARAMETERS
//   SEQ_W    3   width of Q (fixed at 3; the table is defined for 3 bits)
//   SEQ_LEN  6   number of valid steps before wrap (1..8)
// PORTS
//   clk    in   1      rising-edge clock; the only clock
//   clear  in   1      synchronous, active-high reset
//   Q      out  SEQ_W  current sequence code (registered)
//   wrap   out  1      only with SEQGEN_WRAP_EN (see CONFIGURATION)
// BEHAVIOUR
//   - One clock (clk); reset is synchronous and active-high (clear).
//     clear is sampled only on rising clk and has no asynchronous effect.
//   - State: step index idx[2:0], range 0..SEQ_LEN-1, plus registered Q.
//   - Reset: on a rising edge with clear=1, idx<=0 and Q<=3'b000 (wrap<=0).
//     clear overrides everything, including mid-sequence.
//   - Run: on a rising edge with clear=0:
//     - idx <= (idx==SEQ_LEN-1) ? 0 : idx+1
//     - Q <= TABLE[next idx]
//   - Latency: the first edge after clear deasserts makes Q=001. Q holds steady between edges.
//   - Sequence table, index 0..5: 000, 001, 011, 111, 110, 100. Period is SEQ_LEN clocks.
//   - Codes 010 and 101 must never appear on Q.
//   - Illegal-state recovery: if idx>=SEQ_LEN (e.g. after an upset), the next non-clear edge
//     forces idx<=0 and Q<=000. There is no lock-up state.
//   - Before the first clear, Q is X/undefined in simulation. Only clear defines state.
// CONFIGURATION
//   Macro SEQGEN_WRAP_EN:
//   - Defined:
//     - Adds output port `wrap`, 1 bit, registered.
//     - wrap is 1 for exactly the cycle in which Q returns to 000 from the last step (100).
//     - wrap is 0 after reset and 0 during clear.
//     - wrap stays 0 on recovery from an illegal idx.
//   - Undefined: the port and its logic are absent. All other behaviour is identical.
// STRUCTURE
//   - Package seq_gen_pkg:
//     - SEQ_W and SEQ_LEN localparams
//     - SEQ_TABLE constant array [0:7] of SEQ_W-bit codes; entries 6..7 = 000, unused
//     - typedef seq_code_t (logic [SEQ_W-1:0])
//   - Sub-module seq_rom: combinational lookup, idx in -> code out, reading SEQ_TABLE.
//   - The top holds the idx/Q registers, the wrap/recovery next-state logic and the optional wrap flag.
// TESTING
//   - Reset: hold clear=1 for 2 edges -> Q=000 after the first edge (wrap=0 if enabled).
//   - Sequence: clear=0 for 6 edges -> Q = 001, 011, 111, 110, 100, 000 on successive edges.
//     With SEQGEN_WRAP_EN, wrap=1 only with the final 000.
//   - Long run: 20 edges free-running -> Q strictly periodic with period 6; 010 and 101 never seen.
//   - Mid-sequence clear: assert clear while Q=111 -> Q=000 at the next edge.
//     Release -> next edge Q=001.
//   - Recovery: force idx=7 in the bench, clear=0 -> next edge Q=000, idx=0, wrap=0.
//     The following edge gives Q=001.

Source files
------------

// File: rtl/seq_gen_pkg.sv
// Shared constants and types for the 3-bit Johnson-style sequence generator.
// The step table, its valid length and the code type live here so the ROM
// and the top agree on a single definition.
package seq_gen_pkg;

  localparam int SEQ_W   = 3;
  localparam int SEQ_LEN = 6;

  typedef logic [SEQ_W-1:0] seq_code_t;
  typedef logic [2:0]       seq_idx_t;

  // Index of the final valid step; the step after it wraps back to 0.
  localparam seq_idx_t LAST_IDX = seq_idx_t'(SEQ_LEN - 1);

  // Entries 6..7 are unused and decode to 000, so an illegal index can never
  // produce 010 or 101 on the output.
  localparam seq_code_t SEQ_TABLE [0:7] = '{
    3'b000, 3'b001, 3'b011, 3'b111,
    3'b110, 3'b100, 3'b000, 3'b000
  };

endpackage

// File: rtl/seq_rom.sv
// Combinational step-index to code lookup over SEQ_TABLE.
module seq_rom
  import seq_gen_pkg::*;
(
  input  logic [2:0]       idx,
  output logic [SEQ_W-1:0] code
);

  // Pure table read; every index has an entry, so no default is needed.
  always_comb begin
    code = SEQ_TABLE[idx];
  end

endmodule

// File: rtl/sequence_generator.sv
// Free-running 3-bit sequence generator: 000->001->011->111->110->100->000.
// Q is registered and looked up from the index the register is about to hold,
// so Q and idx always move together on the same edge.
// Optional feature: define SEQGEN_WRAP_EN to add the registered `wrap` flag,
// high for the one cycle in which Q returns to 000 from the last step.
module sequence_generator
  import seq_gen_pkg::*;
(
  input  logic             clk,
  input  logic             clear,
  output logic [SEQ_W-1:0] Q
`ifdef SEQGEN_WRAP_EN
  ,
  output logic             wrap
`endif
);

  seq_idx_t  idx;
  seq_idx_t  idx_next;
  seq_code_t code_next;

  // Next step index: advance, wrap after the last step, and pull any
  // out-of-range index (e.g. after an upset) straight back to step 0.
  always_comb begin
    // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
    idx_next = idx + 3'd1;
    if (idx >= LAST_IDX) begin
      idx_next = '0;
    end
  end

  seq_rom u_rom (
    .idx  (idx_next),
    .code (code_next)
  );

  // Index and output code registers; clear is synchronous and wins over run.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (clear) begin
      idx <= '0;
      Q   <= '0;
    end else begin
      idx <= idx_next;
      Q   <= code_next;
    end
  end

`ifdef SEQGEN_WRAP_EN
  // Wrap flag: set only on a genuine last-step -> step-0 transition, so the
  // illegal-index recovery path leaves it low.
  always_ff @(posedge clk) begin
    if (clear) begin
      wrap <= 1'b0;
    end else begin
      wrap <= (idx == LAST_IDX);
    end
  end
`endif

endmodule

// File: tb/tb_sequence_generator.sv
// Self-checking bench for sequence_generator.
// Reference model: a step counter 0..5 whose code is derived arithmetically
// (rising run of ones, then falling run of ones); an out-of-range step marks
// an injected illegal state that must recover to 000 without a wrap pulse.
// Define SEQGEN_WRAP_EN for both RTL and bench to check the wrap flag too.
module tb_sequence_generator;

  logic       clk;
  logic       clear;
  logic [2:0] q;
`ifdef SEQGEN_WRAP_EN
  logic       wrap;
`endif

  int checks;
  int failures;

  int   model_step;   // 0..5 legal, 6/7 = injected illegal index
  logic model_wrap;

  sequence_generator dut (
    .clk   (clk),
    .clear (clear),
    .Q     (q)
`ifdef SEQGEN_WRAP_EN
    ,
    .wrap  (wrap)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Johnson code of step k: k ones filling from the LSB for k<=3, then ones
  // draining from the LSB for k=4,5.
  function automatic logic [2:0] code_of(input int k);
    int v;
    if (k <= 3) v = (1 << k) - 1;
    else        v = 7 & ~((1 << (k - 3)) - 1);
    return 3'(v);
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model one edge under the given clear value.
  task automatic model_edge(input logic c);
    if (c) begin
      model_step = 0;
      model_wrap = 1'b0;
    end else if (model_step > 5) begin
      model_step = 0;
      model_wrap = 1'b0;
    end else if (model_step == 5) begin
      model_step = 0;
      model_wrap = 1'b1;
    end else begin
      model_step = model_step + 1;
      model_wrap = 1'b0;
    end
  endtask

  // Drive clear, take one rising edge, sample 1 time unit later, compare.
  task automatic tick(input logic c, input string tag);
    clear = c;
    @(posedge clk);
    #1;
    model_edge(c);
    check(tag, {5'd0, q}, {5'd0, code_of(model_step)});
    check({tag, "_legal"}, {7'd0, (q == 3'b010) || (q == 3'b101)}, 8'd0);
`ifdef SEQGEN_WRAP_EN
    check({tag, "_wrap"}, {7'd0, wrap}, {7'd0, model_wrap});
`endif
  endtask

  // Inject an illegal index between edges, then check recovery.
  task automatic inject(input logic [2:0] bad, input string tag);
    @(negedge clk);
    force dut.idx = bad;
    #1;
    release dut.idx;
    model_step = int'(bad);
    tick(1'b0, tag);
    check({tag, "_idx"}, {5'd0, dut.idx}, 8'd0);
    tick(1'b0, {tag, "_next"});
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    model_step = 0;
    model_wrap = 1'b0;
    clear      = 1'b1;

    // Reset: two edges with clear held high.
    tick(1'b1, "reset0");
    tick(1'b1, "reset1");

    // One full period from reset: 001 011 111 110 100 000.
    for (int i = 0; i < 6; i++) tick(1'b0, $sformatf("seq%0d", i));

    // Long free run.
    for (int i = 0; i < 20; i++) tick(1'b0, $sformatf("run%0d", i));

    // Mid-sequence clear while Q=111.
    while (model_step != 3) tick(1'b0, "to111");
    check("at111", {5'd0, q}, 8'h07);
    tick(1'b1, "midclear");
    tick(1'b0, "release");

    // Illegal-index recovery from both unused indices.
    inject(3'd7, "recover7");
    tick(1'b0, "post7");
    inject(3'd6, "recover6");

    // Randomised stretch with occasional clear pulses.
    for (int i = 0; i < 80; i++) begin
      tick(($urandom_range(0, 9) == 0), $sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the bench can never hang.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
